layernorm_hls_deadlock_report_unit: RTL
=======================================

Name: layernorm_hls_deadlock_report_unit

Overview:
- Central collector downstream of the per-process deadlock detect units in the layernorm HLS dataflow region.
- Takes every unit's dl_detect_out and picks one origin process.
- Broadcasts the detected state back to all units as dl_detect_in, drives origin and token_clear for the token walk, records which processes the token visits, and presents one report record over a valid/ready handshake.

Parameters:
- PROC_NUM, 4, number of dataflow processes (width of all per-process vectors).
- PROC_ID_W, 2, width of a process index; must equal ceil(log2(PROC_NUM)), minimum 1.
- CYCLE_W, 32, width of the free-running cycle counter and the report timestamp.
- TRACE_TIMEOUT, 1024, maximum cycles spent in TRACE before forced report; must be >= 2.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- dl_detect_vec  in  PROC_NUM  bit p = dl_detect_out of process p's detect unit.
- token_vec  in  PROC_NUM  bit p = OR of process p's token_in_vec.
- dl_detect_in  out  1  broadcast "deadlock detected"; sticky until reset.
- origin  out  PROC_NUM  one-hot, one-cycle pulse to the chosen origin unit.
- token_clear  out  1  one-cycle pulse, ends the token walk.
- report_valid  out  1  report record available.
- report_ready  in  1  consumer accepts the record.
- report_proc_id  out  PROC_ID_W  index of the origin process.
- report_cycle  out  CYCLE_W  cycle count at detection.
- report_path  out  PROC_NUM  processes whose token_in was seen during TRACE, origin included.
- report_timeout  out  1  TRACE ended by timeout rather than by the token returning.

Behaviour:
- Reset (asynchronous, active-high, any state, including mid-TRACE or mid-REPORT):
  - state = IDLE.
  - All outputs 0, cycle_cnt = 0, trace_cnt = 0, all latched fields 0.
- cycle_cnt: increments every cycle after reset and saturates at all-ones (no wrap).
- All outputs are registered; nothing combinational from input to output.
- States: IDLE, TRACE, REPORT, HALT.
- IDLE:
  - On any bit of dl_detect_vec set in cycle N, select the lowest set index id.
  - Latch report_proc_id = id and report_cycle = cycle_cnt value in cycle N.
  - Set report_path = one-hot(id), trace_cnt = 0, report_timeout = 0.
  - In cycle N+1: dl_detect_in = 1 (stays high) and origin = one-hot(id) for exactly one cycle; state = TRACE.
  - Simultaneous detections: only the lowest index is reported; the others are not queued.
- TRACE:
  - Each cycle: report_path |= token_vec; trace_cnt increments.
  - If token_vec[id] = 1: token_clear = 1 in the next cycle for exactly one cycle, then REPORT.
  - If trace_cnt reaches TRACE_TIMEOUT-1 without token_vec[id]: same token_clear pulse, report_timeout = 1, then REPORT.
  - If both occur in the same cycle, the token return wins and report_timeout = 0.
  - token_vec[id] is honoured from the first TRACE cycle.
  - dl_detect_vec is ignored.
- REPORT:
  - report_valid = 1; all report_* fields held stable until the cycle with report_valid & report_ready.
  - After that cycle: report_valid = 0 and state = HALT.
  - Back-pressure of any length is allowed. report_ready while not in REPORT is ignored.
- HALT:
  - Terminal until reset; dl_detect_in stays 1.
  - dl_detect_vec, token_vec and report_ready are ignored; origin and token_clear stay 0.
- Invariants, checked by bench assertions:
  - origin is 0 or one-hot.
  - origin and token_clear are never high in the same cycle.
  - Exactly one origin pulse and one token_clear pulse occur per reset epoch.

Decomposition:
- Shared package layernorm_hls_dl_pkg holds:
  - the state enum (IDLE, TRACE, REPORT, HALT);
  - a clog2 function used to check PROC_ID_W;
  - a report record typedef (proc_id, cycle, path, timeout).
- One sub-module, layernorm_hls_dl_prio_enc: parameterised PROC_NUM lowest-index-first priority encoder giving a valid flag, an index and a one-hot output. Purely combinational; it feeds the IDLE capture registers.

Test Plan:
- Reset released, then dl_detect_vec = 4'b0100 at cycle 10:
  - cycle 11: origin = 4'b0100, dl_detect_in = 1;
  - report_proc_id = 2, report_cycle = 10.
- Token loop: after the origin pulse, token_vec = 4'b1000, then 4'b0001, then 4'b0100 on successive cycles:
  - token_clear pulses once in the cycle after 4'b0100;
  - report_path = 4'b1101, report_timeout = 0.
- Simultaneous dl_detect_vec = 4'b1010 in IDLE:
  - id = 1, origin = 4'b0010;
  - later dl_detect_vec activity has no effect.
- TRACE_TIMEOUT = 8 with no token_vec:
  - token_clear 8 cycles after TRACE entry;
  - report_timeout = 1, report_path = one-hot(id).
- report_ready held low 20 cycles in REPORT:
  - report_valid and all fields stable throughout;
  - ready high for one cycle gives exactly one transfer, then HALT with dl_detect_in = 1.
- Reset asserted mid-TRACE:
  - all outputs 0 immediately;
  - a new detection after release repeats the IDLE behaviour with report_cycle measured from the new reset.

Source files
------------

// File: rtl/layernorm_hls_deadlock_report_unit_pkg.sv
// Shared types for the layernorm HLS deadlock report collector: FSM states,
// the report record layout and a width helper.
package layernorm_hls_dl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      TRACE  = 2'd1,
      REPORT = 2'd2,
      HALT   = 2'd3
   } dl_state_t;

   localparam int DL_PROC_NUM  = 4;
   localparam int DL_PROC_ID_W = 2;
   localparam int DL_CYCLE_W   = 32;

   typedef struct packed {
      logic [DL_PROC_ID_W-1:0] proc_id;
      logic [DL_CYCLE_W-1:0]   cycle;
      logic [DL_PROC_NUM-1:0]  path;
      logic                    timeout;
   } report_rec_t;

   // Index width for n processes, never below one bit.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      if (r < 1) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/layernorm_hls_deadlock_report_unit_if.sv
// Signal bundle between the per-process detect units, the report consumer
// and the central deadlock report collector.
interface layernorm_hls_deadlock_report_unit_if #(
   parameter int PROC_NUM  = 4,
   parameter int PROC_ID_W = 2,
   parameter int CYCLE_W   = 32
);
   logic [PROC_NUM-1:0]  dl_detect_vec;
   logic [PROC_NUM-1:0]  token_vec;
   logic                 dl_detect_in;
   logic [PROC_NUM-1:0]  origin;
   logic                 token_clear;
   logic                 report_valid;
   logic                 report_ready;
   logic [PROC_ID_W-1:0] report_proc_id;
   logic [CYCLE_W-1:0]   report_cycle;
   logic [PROC_NUM-1:0]  report_path;
   logic                 report_timeout;

   modport master (
      input  dl_detect_vec, token_vec, report_ready,
      output dl_detect_in, origin, token_clear, report_valid,
             report_proc_id, report_cycle, report_path, report_timeout
   );

   modport slave (
      output dl_detect_vec, token_vec, report_ready,
      input  dl_detect_in, origin, token_clear, report_valid,
             report_proc_id, report_cycle, report_path, report_timeout
   );
endinterface

// File: rtl/layernorm_hls_deadlock_report_unit_prio_enc.sv
// Lowest-index-first priority encoder: hit flag, binary index and one-hot
// of the winning request.
module layernorm_hls_dl_prio_enc #(
   parameter int PROC_NUM  = 4,
   parameter int PROC_ID_W = 2
) (
   input  logic [PROC_NUM-1:0]  req,
   output logic                 hit,
   output logic [PROC_ID_W-1:0] idx,
   output logic [PROC_NUM-1:0]  onehot
);

   always_comb begin
      hit    = 1'b0;
      idx    = '0;
      onehot = '0;
      for (int i = 0; i < PROC_NUM; i++) begin
         if (req[i] && !hit) begin
            hit       = 1'b1;
            idx       = PROC_ID_W'(i);
            onehot[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/layernorm_hls_deadlock_report_unit.sv
// Central deadlock collector: picks the origin process, runs the token walk,
// records the visited path and hands out a single report record.
module layernorm_hls_deadlock_report_unit
   import layernorm_hls_dl_pkg::*;
#(
   parameter int PROC_NUM      = 4,
   parameter int PROC_ID_W     = 2,
   parameter int CYCLE_W       = 32,
   parameter int TRACE_TIMEOUT = 1024
) (
   input logic clock,
   input logic reset,
   layernorm_hls_deadlock_report_unit_if.master bus
);

   localparam int TC_W = $clog2(TRACE_TIMEOUT);
   localparam logic [TC_W-1:0] TC_LAST = TC_W'(TRACE_TIMEOUT - 1);

   if (PROC_ID_W != clog2(PROC_NUM)) begin : g_id_w_check
      $error("PROC_ID_W must equal clog2(PROC_NUM)");
   end
   if (TRACE_TIMEOUT < 2) begin : g_timeout_check
      $error("TRACE_TIMEOUT must be at least 2");
   end

   dl_state_t            state;
   logic [CYCLE_W-1:0]   cycle_cnt;
   logic [TC_W-1:0]      trace_cnt;
   logic [PROC_ID_W-1:0] id_q;
   logic [CYCLE_W-1:0]   cycle_q;
   logic [PROC_NUM-1:0]  path_q;
   logic                 timeout_q;
   logic                 valid_q;
   logic                 detected_q;
   logic [PROC_NUM-1:0]  origin_q;
   logic                 token_clear_q;

   logic                 enc_hit;
   logic [PROC_ID_W-1:0] enc_idx;
   logic [PROC_NUM-1:0]  enc_onehot;

   layernorm_hls_dl_prio_enc #(
      .PROC_NUM  (PROC_NUM),
      .PROC_ID_W (PROC_ID_W)
   ) u_prio_enc (
      .req    (bus.dl_detect_vec),
      .hit    (enc_hit),
      .idx    (enc_idx),
      .onehot (enc_onehot)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         cycle_cnt     <= '0;
         trace_cnt     <= '0;
         id_q          <= '0;
         cycle_q       <= '0;
         path_q        <= '0;
         timeout_q     <= 1'b0;
         valid_q       <= 1'b0;
         detected_q    <= 1'b0;
         origin_q      <= '0;
         token_clear_q <= 1'b0;
      end else begin
         if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
         // origin and token_clear are single-cycle strobes by default
         origin_q      <= '0;
         token_clear_q <= 1'b0;
         case (state)
            IDLE: begin
               if (enc_hit) begin
                  id_q       <= enc_idx;
                  cycle_q    <= cycle_cnt;
                  path_q     <= enc_onehot;
                  trace_cnt  <= '0;
                  timeout_q  <= 1'b0;
                  detected_q <= 1'b1;
                  origin_q   <= enc_onehot;
                  state      <= TRACE;
               end
            end
            TRACE: begin
               path_q    <= path_q | bus.token_vec;
               trace_cnt <= trace_cnt + 1'b1;
               // A returning token takes precedence over an expiring timer.
               if (bus.token_vec[id_q]) begin
                  token_clear_q <= 1'b1;
                  valid_q       <= 1'b1;
                  state         <= REPORT;
               end else if (trace_cnt == TC_LAST) begin
                  token_clear_q <= 1'b1;
                  timeout_q     <= 1'b1;
                  valid_q       <= 1'b1;
                  state         <= REPORT;
               end
            end
            REPORT: begin
               if (bus.report_ready) begin
                  valid_q <= 1'b0;
                  state   <= HALT;
               end
            end
            HALT: begin
               state <= HALT;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.dl_detect_in   = detected_q;
   assign bus.origin         = origin_q;
   assign bus.token_clear    = token_clear_q;
   assign bus.report_valid   = valid_q;
   assign bus.report_proc_id = id_q;
   assign bus.report_cycle   = cycle_q;
   assign bus.report_path    = path_q;
   assign bus.report_timeout = timeout_q;

endmodule
